// File: rtl/pc_update_unit.sv
//==============================================================================
// Module   : pc_update_unit
// Purpose  : Program-counter update unit for a multi-cycle MIPS-style core.
//            Selects the next-PC candidate, applies the write enable, and
//            handles exceptions and misaligned-target traps by saving the
//            current PC into EPC and vectoring to EXC_VECTOR. Also keeps a
//            saturating count of taken conditional branches.
//
// Ports    :
//   clk           in   1   system clock, rising-edge active
//   reset         in   1   asynchronous active-high reset
//   pc_write      in   1   unconditional PC write enable
//   pc_write_cond in   1   conditional (branch) PC write enable
//   branch_cond   in   1   selected branch condition
//   pc_source     in   3   next-PC source select
//   alu_result    in  32   combinational ALU output (PC+4)
//   alu_out       in  32   registered ALU output (branch target)
//   jump_index    in  26   J-type instruction index field
//   exc_req       in   1   exception request
//   cnt_clr       in   1   synchronous clear of the taken-branch counter
//   pc            out 32   current program counter
//   epc           out 32   exception program counter
//   pc_loaded     out  1   pulse, cycle after any PC load
//   misalign      out  1   pulse, cycle after a misaligned-target trap
//   taken_cnt     out 16   saturating taken-branch count
//
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_update_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h000000FC,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_cond,
    input  logic [2:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [25:0] jump_index,
    input  logic        exc_req,
    input  logic        cnt_clr,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        pc_loaded,
    output logic        misalign,
    output logic [15:0] taken_cnt
);

    localparam logic [2:0]  c_SRC_ALU_RESULT = 3'b000;
    localparam logic [2:0]  c_SRC_ALU_OUT    = 3'b001;
    localparam logic [2:0]  c_SRC_JUMP       = 3'b010;
    localparam logic [2:0]  c_SRC_EPC        = 3'b011;
    localparam logic [2:0]  c_SRC_EXC_VECTOR = 3'b100;
    localparam logic [15:0] c_CNT_MAX        = 16'hFFFF;

    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_pcLoaded;
    logic        r_misalign;
    logic [15:0] r_takenCnt;

    logic [31:0] w_candidate;
    logic        w_srcValid;
    logic        w_trapExempt;
    logic        w_we;
    logic        w_trap;
    logic        w_normalWrite;
    logic        w_takenBranch;

    // Next-PC candidate mux; reserved encodings flag themselves invalid so
    // the write enable can be suppressed.
    always_comb begin
        w_candidate  = r_pc;
        w_srcValid   = 1'b1;
        w_trapExempt = 1'b0;
        case (pc_source)
            c_SRC_ALU_RESULT: w_candidate = alu_result;
            c_SRC_ALU_OUT:    w_candidate = alu_out;
            c_SRC_JUMP:       w_candidate = {r_pc[31:28], jump_index, 2'b00};
            c_SRC_EPC: begin
                // Returning from an exception or vectoring to the handler
                // always loads the value untouched.
                w_candidate  = r_epc;
                w_trapExempt = 1'b1;
            end
            c_SRC_EXC_VECTOR: begin
                w_candidate  = EXC_VECTOR;
                w_trapExempt = 1'b1;
            end
            default: w_srcValid = 1'b0;
        endcase
    end

    assign w_we          = (pc_write | (pc_write_cond & branch_cond)) & w_srcValid;
    assign w_trap        = ~exc_req & w_we & ~w_trapExempt & (w_candidate[1:0] != 2'b00);
    assign w_normalWrite = ~exc_req & w_we & ~w_trap;
    // Only a branch that actually redirected the PC counts as taken.
    assign w_takenBranch = w_normalWrite & pc_write_cond & branch_cond;

    // PC / EPC and the one-cycle status pulses. Priority: exception, trap,
    // normal write, hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_epc      <= 32'h0;
            r_pcLoaded <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_pcLoaded <= 1'b0;
            r_misalign <= 1'b0;
            if (exc_req) begin
                r_epc      <= r_pc;
                r_pc       <= EXC_VECTOR;
                r_pcLoaded <= 1'b1;
            end else if (w_trap) begin
                r_epc      <= r_pc;
                r_pc       <= EXC_VECTOR;
                r_pcLoaded <= 1'b1;
                r_misalign <= 1'b1;
            end else if (w_normalWrite) begin
                r_pc       <= w_candidate;
                r_pcLoaded <= 1'b1;
            end
        end
    end

    // Saturating taken-branch counter; clear beats a same-edge increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_takenCnt <= 16'h0;
        end else if (cnt_clr) begin
            r_takenCnt <= 16'h0;
        end else if (w_takenBranch && (r_takenCnt != c_CNT_MAX)) begin
            r_takenCnt <= r_takenCnt + 16'd1;
        end
    end

    assign pc        = r_pc;
    assign epc       = r_epc;
    assign pc_loaded = r_pcLoaded;
    assign misalign  = r_misalign;
    assign taken_cnt = r_takenCnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
//==============================================================================
// Module   : tb_pc_update_unit
// Purpose  : Self-checking bench for pc_update_unit. Each scenario task queues
//            its expected register state, drives stimulus one clock at a time
//            and pops/compares the expectation after each edge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_update_unit;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_cond;
    logic [2:0]  pc_source;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [25:0] jump_index;
    logic        exc_req;
    logic        cnt_clr;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pc_loaded;
    logic        misalign;
    logic [15:0] taken_cnt;

    int nCmp = 0;
    int nErr = 0;

    typedef struct {
        logic        pw;
        logic        pwc;
        logic        bc;
        logic [2:0]  src;
        logic [31:0] ar;
        logic [31:0] ao;
        logic [25:0] ji;
        logic        exc;
        logic        clr;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        ld;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];

    pc_update_unit #(
        .EXC_VECTOR(32'h000000FC),
        .RESET_PC  (32'h00000000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .branch_cond  (branch_cond),
        .pc_source    (pc_source),
        .alu_result   (alu_result),
        .alu_out      (alu_out),
        .jump_index   (jump_index),
        .exc_req      (exc_req),
        .cnt_clr      (cnt_clr),
        .pc           (pc),
        .epc          (epc),
        .pc_loaded    (pc_loaded),
        .misalign     (misalign),
        .taken_cnt    (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t S(logic pw, logic pwc, logic bc, logic [2:0] src,
                                logic [31:0] ar, logic [31:0] ao, logic [25:0] ji,
                                logic exc, logic clr);
        stim_t s;
        s.pw = pw; s.pwc = pwc; s.bc = bc; s.src = src;
        s.ar = ar; s.ao = ao; s.ji = ji; s.exc = exc; s.clr = clr;
        return s;
    endfunction

    function automatic exp_t E(string n, logic [31:0] p, logic [31:0] ep,
                               logic ld, logic mis, logic [15:0] c);
        exp_t e;
        e.name = n; e.pc = p; e.epc = ep; e.ld = ld; e.mis = mis; e.cnt = c;
        return e;
    endfunction

    task automatic set_inputs(input stim_t s);
        pc_write      = s.pw;
        pc_write_cond = s.pwc;
        branch_cond   = s.bc;
        pc_source     = s.src;
        alu_result    = s.ar;
        alu_out       = s.ao;
        jump_index    = s.ji;
        exc_req       = s.exc;
        cnt_clr       = s.clr;
    endtask

    // Apply one stimulus vector for exactly one rising edge, then sample
    // just after that edge.
    task automatic drive(input stim_t s);
        @(negedge clk);
        set_inputs(s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        set_inputs(S(1, 1, 1, 3'd0, 32'h4, 32'h8, 26'h0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        sbq.push_back(E("reset_state", 32'h0, 32'h0, 1'b0, 1'b0, 16'h0));
        e = sbq.pop_front();
        nCmp++;
        if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
            nErr++;
            $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                     e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
        end
        @(negedge clk);
        set_inputs(S(0, 0, 0, 3'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0));
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        stim_t s[$];
        exp_t  e;
        s.push_back(S(1, 0, 0, 3'd0, 32'h4,  32'h0, 26'h0, 0, 0)); sbq.push_back(E("fetch_4",    32'h4, 32'h0, 1, 0, 16'h0));
        s.push_back(S(1, 0, 0, 3'd0, 32'h8,  32'h0, 26'h0, 0, 0)); sbq.push_back(E("fetch_8",    32'h8, 32'h0, 1, 0, 16'h0));
        s.push_back(S(1, 0, 0, 3'd0, 32'hC,  32'h0, 26'h0, 0, 0)); sbq.push_back(E("fetch_12",   32'hC, 32'h0, 1, 0, 16'h0));
        s.push_back(S(0, 0, 0, 3'd0, 32'h99, 32'h0, 26'h0, 0, 0)); sbq.push_back(E("fetch_hold", 32'hC, 32'h0, 0, 0, 16'h0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sbq.pop_front();
            nCmp++;
            if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
                nErr++;
                $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                         e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        exp_t  e;
        s.push_back(S(0, 1, 0, 3'd1, 32'h0,  32'h40, 26'h0, 0, 0)); sbq.push_back(E("br_not_taken", 32'hC,  32'h0, 0, 0, 16'h0));
        s.push_back(S(0, 1, 1, 3'd1, 32'h0,  32'h40, 26'h0, 0, 0)); sbq.push_back(E("br_taken",     32'h40, 32'h0, 1, 0, 16'h1));
        s.push_back(S(1, 1, 1, 3'd5, 32'h80, 32'h80, 26'h0, 0, 0)); sbq.push_back(E("src_reserved", 32'h40, 32'h0, 0, 0, 16'h1));
        s.push_back(S(1, 0, 0, 3'd1, 32'h0,  32'h44, 26'h0, 0, 0)); sbq.push_back(E("pw_only",      32'h44, 32'h0, 1, 0, 16'h1));
        s.push_back(S(1, 1, 1, 3'd1, 32'h0,  32'h48, 26'h0, 0, 0)); sbq.push_back(E("pw_and_br",    32'h48, 32'h0, 1, 0, 16'h2));
        foreach (s[i]) begin
            drive(s[i]);
            e = sbq.pop_front();
            nCmp++;
            if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
                nErr++;
                $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                         e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
            end
        end
    endtask

    task automatic test_jump();
        stim_t s[$];
        exp_t  e;
        s.push_back(S(1, 0, 0, 3'd0, 32'h30000010, 32'h0, 26'h0,     0, 0)); sbq.push_back(E("jump_setup", 32'h30000010, 32'h0, 1, 0, 16'h2));
        s.push_back(S(1, 0, 0, 3'd2, 32'h0,        32'h0, 26'h0000100, 0, 0)); sbq.push_back(E("jump",     32'h30000400, 32'h0, 1, 0, 16'h2));
        foreach (s[i]) begin
            drive(s[i]);
            e = sbq.pop_front();
            nCmp++;
            if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
                nErr++;
                $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                         e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
            end
        end
    endtask

    task automatic test_exception();
        stim_t s[$];
        exp_t  e;
        s.push_back(S(1, 0, 0, 3'd0, 32'h20, 32'h0, 26'h0, 0, 0)); sbq.push_back(E("exc_setup",   32'h20, 32'h0,  1, 0, 16'h2));
        s.push_back(S(1, 1, 1, 3'd0, 32'h24, 32'h0, 26'h0, 1, 0)); sbq.push_back(E("exc_req",     32'hFC, 32'h20, 1, 0, 16'h2));
        s.push_back(S(1, 0, 0, 3'd3, 32'h0,  32'h0, 26'h0, 0, 0)); sbq.push_back(E("eret",        32'h20, 32'h20, 1, 0, 16'h2));
        s.push_back(S(0, 0, 0, 3'd7, 32'h0,  32'h0, 26'h0, 1, 0)); sbq.push_back(E("exc_no_we",   32'hFC, 32'h20, 1, 0, 16'h2));
        s.push_back(S(1, 0, 0, 3'd4, 32'h0,  32'h0, 26'h0, 0, 0)); sbq.push_back(E("src_vector",  32'hFC, 32'h20, 1, 0, 16'h2));
        s.push_back(S(0, 0, 0, 3'd0, 32'h0,  32'h0, 26'h0, 0, 0)); sbq.push_back(E("exc_idle",    32'hFC, 32'h20, 0, 0, 16'h2));
        foreach (s[i]) begin
            drive(s[i]);
            e = sbq.pop_front();
            nCmp++;
            if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
                nErr++;
                $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                         e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
            end
        end
    endtask

    task automatic test_misalign();
        stim_t s[$];
        exp_t  e;
        s.push_back(S(1, 0, 0, 3'd0, 32'h10,  32'h0,  26'h0, 0, 0)); sbq.push_back(E("mis_setup",    32'h10, 32'h20, 1, 0, 16'h2));
        s.push_back(S(0, 1, 1, 3'd1, 32'h0,   32'h42, 26'h0, 0, 0)); sbq.push_back(E("mis_branch",   32'hFC, 32'h10, 1, 1, 16'h2));
        s.push_back(S(0, 0, 0, 3'd0, 32'h0,   32'h0,  26'h0, 0, 0)); sbq.push_back(E("mis_pulse_end",32'hFC, 32'h10, 0, 0, 16'h2));
        s.push_back(S(1, 0, 0, 3'd0, 32'h102, 32'h0,  26'h0, 0, 0)); sbq.push_back(E("mis_pw",       32'hFC, 32'hFC, 1, 1, 16'h2));
        s.push_back(S(0, 1, 0, 3'd1, 32'h0,   32'h43, 26'h0, 0, 0)); sbq.push_back(E("mis_no_we",    32'hFC, 32'hFC, 0, 0, 16'h2));
        s.push_back(S(1, 0, 0, 3'd0, 32'h101, 32'h0,  26'h0, 1, 0)); sbq.push_back(E("mis_exc_wins", 32'hFC, 32'hFC, 1, 0, 16'h2));
        foreach (s[i]) begin
            drive(s[i]);
            e = sbq.pop_front();
            nCmp++;
            if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
                nErr++;
                $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                         e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        stim_t s[$];
        exp_t  e;
        // Clear alone, then preload to 0xFFFE with taken branches.
        sbq.push_back(E("cnt_clr",      32'hFC, 32'hFC, 0, 0, 16'h0));
        sbq.push_back(E("cnt_preload",  32'h40, 32'hFC, 1, 0, 16'hFFFE));
        drive(S(0, 0, 0, 3'd0, 32'h0, 32'h0, 26'h0, 0, 1));
        e = sbq.pop_front();
        nCmp++;
        if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
            nErr++;
            $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                     e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
        end
        for (int k = 0; k < 32'hFFFE; k++) drive(S(0, 1, 1, 3'd1, 32'h0, 32'h40, 26'h0, 0, 0));
        e = sbq.pop_front();
        nCmp++;
        if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
            nErr++;
            $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                     e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
        end
        s.push_back(S(0, 1, 1, 3'd1, 32'h0, 32'h40, 26'h0, 0, 0)); sbq.push_back(E("cnt_max",      32'h40, 32'hFC, 1, 0, 16'hFFFF));
        s.push_back(S(0, 1, 1, 3'd1, 32'h0, 32'h40, 26'h0, 0, 0)); sbq.push_back(E("cnt_saturate", 32'h40, 32'hFC, 1, 0, 16'hFFFF));
        s.push_back(S(0, 1, 1, 3'd1, 32'h0, 32'h60, 26'h0, 0, 1)); sbq.push_back(E("cnt_clr_wins", 32'h60, 32'hFC, 1, 0, 16'h0));
        foreach (s[i]) begin
            drive(s[i]);
            e = sbq.pop_front();
            nCmp++;
            if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
                nErr++;
                $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                         e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        sbq.push_back(E("ares_setup", 32'h80, 32'hFC, 1, 0, 16'h1));
        sbq.push_back(E("ares_now",   32'h0,  32'h0,  0, 0, 16'h0));
        sbq.push_back(E("ares_first", 32'h8,  32'h0,  1, 0, 16'h0));
        drive(S(0, 1, 1, 3'd1, 32'h0, 32'h80, 26'h0, 0, 0));
        e = sbq.pop_front();
        nCmp++;
        if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
            nErr++;
            $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                     e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
        end
        // Reset lands between edges with a write pending on the inputs.
        @(negedge clk);
        set_inputs(S(1, 1, 1, 3'd0, 32'h84, 32'h0, 26'h0, 0, 0));
        #2 reset = 1'b1;
        #1;
        e = sbq.pop_front();
        nCmp++;
        if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
            nErr++;
            $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                     e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        drive(S(1, 0, 0, 3'd0, 32'h8, 32'h0, 26'h0, 0, 0));
        e = sbq.pop_front();
        nCmp++;
        if ({pc, epc, pc_loaded, misalign, taken_cnt} !== {e.pc, e.epc, e.ld, e.mis, e.cnt}) begin
            nErr++;
            $display("FAIL %s: got pc=%h epc=%h ld=%b mis=%b cnt=%h, want pc=%h epc=%h ld=%b mis=%b cnt=%h",
                     e.name, pc, epc, pc_loaded, misalign, taken_cnt, e.pc, e.epc, e.ld, e.mis, e.cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_exception();
        test_misalign();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

`default_nettype wire
